// File: rtl/hd_addr_responder_pkg.sv
// rtl/hd_addr_responder_pkg.sv - shared encodings and defaults for the HD address path
package hd_addr_responder_pkg;

  typedef enum logic [1:0] {
    REGION_COPY = 2'd0,
    REGION_CTX  = 2'd1,
    REGION_PAGE = 2'd2
  } region_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_PID   = 2'd2
  } err_e;

  localparam int unsigned REG_BASE_DEF  = 500;
  localparam int unsigned PAGE_BASE_DEF = 800;
  localparam int unsigned SLOT_DEF      = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/hd_addr_responder_array.sv
// rtl/hd_addr_responder_array.sv - single-port synchronous word array backing the HD space
module hd_word_array #(
  parameter int DEPTH  = 2048,
  parameter int DATA_W = 32,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hd_addr_responder.sv
// rtl/hd_addr_responder.sv - decodes HD addresses into region/pid/index and serves one access at a time
module hd_addr_responder
  import hd_addr_responder_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2048,
  parameter int REG_BASE  = REG_BASE_DEF,
  parameter int PAGE_BASE = PAGE_BASE_DEF,
  parameter int SLOT      = SLOT_DEF,
  parameter int ACC_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [13:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_chk_en,
  input  logic [13:0]       req_pid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [1:0]        rsp_region,
  output logic [13:0]       rsp_pid,
  output logic [7:0]        rsp_index
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ACC_LAT + 1);
  localparam logic [13:0] DEPTH_A     = 14'(DEPTH);
  localparam logic [13:0] REG_BASE_A  = 14'(REG_BASE);
  localparam logic [13:0] PAGE_BASE_A = 14'(PAGE_BASE);
  localparam logic [13:0] SLOT_A      = 14'(SLOT);

  state_e            state;
  logic              we_r;
  logic              chk_r;
  logic [AW-1:0]     addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [13:0]       req_pid_r;
  logic [13:0]       off;
  logic [CW-1:0]     cnt;

  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // The array is addressed with the live request in IDLE so region-0 reads are primed at accept time.
  assign ram_addr = (state == ST_IDLE) ? req_addr[AW-1:0] : addr_r;
  assign ram_we   = (state == ST_ACCESS) && (cnt == CW'(1)) && we_r;

  hd_word_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_r),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= ERR_OK;
      rsp_region <= REGION_COPY;
      rsp_pid    <= '0;
      rsp_index  <= '0;
      we_r       <= 1'b0;
      chk_r      <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      req_pid_r  <= '0;
      off        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            we_r       <= req_we;
            chk_r      <= req_chk_en;
            addr_r     <= req_addr[AW-1:0];
            wdata_r    <= req_wdata;
            req_pid_r  <= req_pid;
            rsp_rdata  <= '0;
            rsp_err    <= ERR_OK;
            rsp_pid    <= '0;
            rsp_index  <= '0;
            rsp_region <= REGION_COPY;
            if (req_addr >= DEPTH_A) begin
              rsp_err <= ERR_RANGE;
              state   <= ST_RESP;
            end else if (req_addr < REG_BASE_A) begin
              rsp_index <= req_addr[7:0];
              cnt       <= CW'(ACC_LAT);
              state     <= ST_ACCESS;
            end else if (req_addr < PAGE_BASE_A) begin
              rsp_region <= REGION_CTX;
              off        <= req_addr - REG_BASE_A;
              state      <= ST_DECODE;
            end else begin
              rsp_region <= REGION_PAGE;
              off        <= req_addr - PAGE_BASE_A;
              state      <= ST_DECODE;
            end
          end
        end
        // Serial divide by SLOT: one subtraction per cycle, pid counts the slots consumed.
        ST_DECODE: begin
          if (off >= SLOT_A) begin
            off     <= off - SLOT_A;
            rsp_pid <= rsp_pid + 14'd1;
          end else begin
            rsp_index <= off[7:0];
            if (chk_r && (rsp_pid != req_pid_r)) begin
              rsp_err <= ERR_PID;
              state   <= ST_RESP;
            end else begin
              cnt   <= CW'(ACC_LAT);
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == CW'(1)) begin
            if (!we_r) rsp_rdata <= ram_rdata;
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
